addsub_pipe: RTL

//  Parametrised, pipelined two's-complement adder/subtractor for the adaptive-filter datapath
//  (coefficient update, error computation). Generalises the fixed 10-bit ripple add/sub.

---
 rtl/addsub_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor with a valid/ready stream interface.
// The carry chain is split into STAGES registered segments. Define ADDSUB_SAT_EN to clamp on overflow.
module addsub_pipe #(
  parameter int WIDTH  = 10,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_x,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

  logic adv;

  // The whole pipeline moves in lockstep: it advances only when the output slot is free.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO     = s * SEG;
    localparam int HI     = ((s + 1) * SEG > WIDTH) ? WIDTH - 1 : (s + 1) * SEG - 1;
    localparam bit ACTIVE = LO < WIDTH;
    localparam bit LAST   = (s == STAGES - 1);

    logic             v_i, c_i, ovf_i;
    logic [WIDTH-1:0] r_i;
    logic             c_sum, ovf_sum;
    logic [WIDTH-1:0] r_sum, r_nxt;
    logic             v_d, v_q, c_d, c_q, ovf_d, ovf_q;
    logic [WIDTH-1:0] r_d, r_q;

    if (s == 0) begin : g_head
      assign v_i   = in_valid;
      assign c_i   = in_sub;
      assign ovf_i = 1'b0;
      assign r_i   = '0;
    end else begin : g_link
      assign v_i   = g_stage[s-1].v_q;
      assign c_i   = g_stage[s-1].c_q;
      assign ovf_i = g_stage[s-1].ovf_q;
      assign r_i   = g_stage[s-1].r_q;
    end

    if (ACTIVE) begin : g_add
      // Only operand bits from LO upward are still needed by this and later stages.
      logic [WIDTH-1:LO] y_i, x_i;
      logic [HI-LO+1:0]  seg_sum;

      if (s == 0) begin : g_ops
        assign y_i = in_y;
        assign x_i = in_x ^ {WIDTH{in_sub}};
      end else begin : g_ops
        assign y_i = g_stage[s-1].g_add.g_rem.y_q;
        assign x_i = g_stage[s-1].g_add.g_rem.x_q;
      end

      always_comb begin
        seg_sum        = {1'b0, y_i[HI:LO]} + {1'b0, x_i[HI:LO]} + {{(HI-LO+1){1'b0}}, c_i};
        r_sum          = r_i;
        r_sum[HI:LO]   = seg_sum[HI-LO:0];
        c_sum          = seg_sum[HI-LO+1];
      end

      if (HI == WIDTH - 1) begin : g_msb
        assign ovf_sum = ovf_i |
                         ((y_i[WIDTH-1] == x_i[WIDTH-1]) && (r_sum[WIDTH-1] != y_i[WIDTH-1]));
      end else begin : g_rem
        logic [WIDTH-1:HI+1] y_d, y_q, x_d, x_q;

        assign ovf_sum = ovf_i;

        always_comb begin
          y_d = y_q;
          x_d = x_q;
          if (adv) begin
            y_d = y_i[WIDTH-1:HI+1];
            x_d = x_i[WIDTH-1:HI+1];
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            y_q <= '0;
            x_q <= '0;
          end else begin
            y_q <= y_d;
            x_q <= x_d;
          end
        end
      end
    end else begin : g_pass
      assign r_sum   = r_i;
      assign c_sum   = c_i;
      assign ovf_sum = ovf_i;
    end

    if (LAST) begin : g_out
`ifdef ADDSUB_SAT_EN
      // On overflow the wrapped MSB is the inverse of the true sign.
      always_comb begin
        r_nxt = r_sum;
        if (ovf_sum) begin
          r_nxt = r_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        end
      end
`else
      assign r_nxt = r_sum;
`endif
      assign out_valid = v_q;
      assign out_res   = r_q;
      assign out_cout  = c_q;
      assign out_ovf   = ovf_q;
    end else begin : g_mid
      assign r_nxt = r_sum;
    end

    always_comb begin
      v_d   = v_q;
      c_d   = c_q;
      ovf_d = ovf_q;
      r_d   = r_q;
      if (adv) begin
        v_d   = v_i;
        c_d   = c_sum;
        ovf_d = ovf_sum;
        r_d   = r_nxt;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        ovf_q <= 1'b0;
        r_q   <= '0;
      end else begin
        v_q   <= v_d;
        c_q   <= c_d;
        ovf_q <= ovf_d;
        r_q   <= r_d;
      end
    end
  end

endmodule
